// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: memory-controller request/response and
// instruction-queue push. The fetch stage is the master; the memory
// controller plus instruction queue side is the slave.
interface instruction_fetch_if;
  // Instruction queue side
  logic        isq_full;
  logic        instruction_ready;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  // Memory controller side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport master (
    input  isq_full,
    input  mem_ready,
    input  mem_data,
    output instruction_ready,
    output instruction_out,
    output pc_out,
    output mem_req,
    output mem_addr
  );

  modport slave (
    output isq_full,
    output mem_ready,
    output mem_data,
    input  instruction_ready,
    input  instruction_out,
    input  pc_out,
    input  mem_req,
    input  mem_addr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, looks it up in a
// direct-mapped one-word-per-line instruction cache, fetches misses from
// the memory controller and pushes (instruction, pc) to the instruction
// queue. A roll_back pulse redirects fetch; an in-flight memory request is
// always completed (and cached) but its word is never pushed.
//
// Optional build macro: FETCH_JAL_PREDICT_EN
//   defined   - a pushed JAL redirects fetch to its target immediately
//   undefined - fetch always continues at pc+4
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_IDX_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                roll_back,
  input  logic [31:0]         roll_back_pc,
  instruction_fetch_if.master bus
);

  localparam int unsigned LINES = 1 << ICACHE_IDX_W;
  localparam int unsigned TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t                  state;
  logic [31:0]             pc;
  logic [29:0]             req_word;

  logic [LINES-1:0]        line_valid;
  logic [31:0]             line_data [LINES];
  logic [TAG_W-1:0]        line_tag  [LINES];

  logic [ICACHE_IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    launch;
  logic                    fill_en;
  logic [31:0]             hit_word;
  logic [31:0]             hit_next_pc;
  logic [31:0]             fill_next_pc;

`ifdef FETCH_JAL_PREDICT_EN
  function automatic logic is_jal(input logic [31:0] word);
    return word[6:0] == 7'b1101111;
  endfunction

  function automatic logic [31:0] jal_offset(input logic [31:0] word);
    return {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
  endfunction
`endif

  // The request address is kept word-granular; the low bits are always zero.
  assign bus.mem_addr = {req_word, 2'b00};

  // Cache lookup, fill addressing and next-PC selection for both push paths.
  always_comb begin
    pc_idx       = pc[ICACHE_IDX_W+1:2];
    pc_tag       = pc[31:ICACHE_IDX_W+2];
    fill_idx     = req_word[ICACHE_IDX_W-1:0];
    fill_tag     = req_word[29:ICACHE_IDX_W];
    hit_word     = line_data[pc_idx];
    hit          = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
    // One launch per two cycles so isq_full already reflects the last push.
    launch       = (state == IDLE) && !bus.isq_full && !bus.instruction_ready;
    // Fills land in WAIT and DISCARD alike, with or without a roll_back.
    fill_en      = rdy_in && (state != IDLE) && bus.mem_ready;
    hit_next_pc  = pc + 32'd4;
    fill_next_pc = pc + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
    if (is_jal(hit_word))
      hit_next_pc = pc + jal_offset(hit_word);
    if (is_jal(bus.mem_data))
      fill_next_pc = pc + jal_offset(bus.mem_data);
`endif
  end

  // Cache data/tag storage: written on every accepted memory response.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      line_data[fill_idx] <= bus.mem_data;
      line_tag[fill_idx]  <= fill_tag;
    end
  end

  // Fetch control FSM: PC, valid bits, memory request and queue push.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                 <= IDLE;
      pc                    <= RESET_PC;
      req_word              <= '0;
      line_valid            <= '0;
      bus.mem_req           <= 1'b0;
      bus.instruction_ready <= 1'b0;
      bus.instruction_out   <= '0;
      bus.pc_out            <= '0;
    end else if (rdy_in) begin
      bus.instruction_ready <= 1'b0;

      if (fill_en)
        line_valid[fill_idx] <= 1'b1;

      if (roll_back) begin
        // Redirect wins over everything; any push due this edge is dropped.
        pc <= roll_back_pc;
        case (state)
          WAIT: begin
            if (bus.mem_ready) begin
              bus.mem_req <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DISCARD;
            end
          end
          DISCARD: begin
            if (bus.mem_ready) begin
              bus.mem_req <= 1'b0;
              state       <= IDLE;
            end
          end
          default: ;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              if (hit) begin
                bus.instruction_ready <= 1'b1;
                bus.instruction_out   <= hit_word;
                bus.pc_out            <= pc;
                pc                    <= hit_next_pc;
              end else begin
                bus.mem_req <= 1'b1;
                req_word    <= pc[31:2];
                state       <= WAIT;
              end
            end
          end
          WAIT: begin
            // Pushed even if isq_full: capacity was checked at launch.
            if (bus.mem_ready) begin
              bus.instruction_ready <= 1'b1;
              bus.instruction_out   <= bus.mem_data;
              bus.pc_out            <= pc;
              pc                    <= fill_next_pc;
              bus.mem_req           <= 1'b0;
              state                 <= IDLE;
            end
          end
          DISCARD: begin
            if (bus.mem_ready) begin
              bus.mem_req <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a word-addressed memory model, a model of
// the expected fetch stream (PC sequence and instruction words) and a model
// of which addresses are resident in the direct-mapped cache.
module tb_instruction_fetch;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic [31:0] roll_back_pc;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC    (32'h0000_0000),
    .ICACHE_IDX_W(5)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .roll_back   (roll_back),
    .roll_back_pc(roll_back_pc),
    .bus         (bus.master)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int          n_cmp;
  int          n_err;
  int          n_push;
  int          cnt;
  bit          mem_auto;
  bit          prev_ir;
  logic [31:0] m_pc;
  logic [31:0] last_pc;
  bit          m_valid [32];
  logic [24:0] m_tag   [32];

  // Memory image: address 0x20 holds "jal x0,+16", all others a non-JAL word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h20) w = 32'h0100_006F;
    else             w = {a[26:2], 7'h13};
    return w;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
    int off;
    off = 4;
`ifdef FETCH_JAL_PREDICT_EN
    if (w[6:0] == 7'b1101111)
      off = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
            - (w[31] ? 1048576 : 0);
`endif
    return pc + off;
  endfunction

  function automatic bit cached(input logic [31:0] a);
    return m_valid[a[6:2]] && (m_tag[a[6:2]] == a[31:7]);
  endfunction

  task automatic mark(input logic [31:0] a);
    m_valid[a[6:2]] = 1'b1;
    m_tag[a[6:2]]   = a[31:7];
  endtask

  // One clock: observe pushes against the stream model, then run the memory.
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rst_in && rdy_in) begin
      if (bus.instruction_ready === 1'b1) begin
        n_cmp++;
        if (prev_ir) begin
          n_err++;
          $display("FAIL push_spacing: back-to-back push at pc_out=%h, required a gap cycle", bus.pc_out);
        end
        n_cmp++;
        if (bus.pc_out !== m_pc) begin
          n_err++;
          $display("FAIL push_pc: got %h, expected %h", bus.pc_out, m_pc);
        end
        n_cmp++;
        if (bus.instruction_out !== mem_word(m_pc)) begin
          n_err++;
          $display("FAIL push_word: got %h, expected %h", bus.instruction_out, mem_word(m_pc));
        end
        last_pc = bus.pc_out;
        n_push++;
        m_pc = model_next(m_pc, mem_word(m_pc));
      end
      prev_ir = (bus.instruction_ready === 1'b1);
    end
    if (mem_auto) begin
      bus.mem_ready = 1'b0;
      if (bus.mem_req !== 1'b1) begin
        cnt = -1;
      end else if (cnt < 0) begin
        n_cmp++;
        if (bus.mem_addr !== m_pc) begin
          n_err++;
          $display("FAIL req_addr: got %h, expected %h", bus.mem_addr, m_pc);
        end
        n_cmp++;
        if (cached(bus.mem_addr)) begin
          n_err++;
          $display("FAIL req_on_hit: request for resident address %h, expected none", bus.mem_addr);
        end
        cnt = int'($urandom_range(0, 3));
      end else if (cnt == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_data  = mem_word(bus.mem_addr);
        mark(bus.mem_addr);
        cnt = -1;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic wait_mem_req(input string name, input int limit);
    int k;
    k = 0;
    while (bus.mem_req !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL %s: mem_req=%b after %0d cycles, expected 1", name, bus.mem_req, limit);
    end
  endtask

  task automatic wait_push(input string name, input int limit);
    int k;
    int start;
    k = 0;
    start = n_push;
    while (n_push == start && k < limit) begin
      tick();
      k++;
    end
    n_cmp++;
    if (n_push == start) begin
      n_err++;
      $display("FAIL %s: no push within %0d cycles, expected one", name, limit);
    end
  endtask

  // Stop new launches, let any request drain, then redirect while IDLE.
  task automatic freeze_and_rollback(input logic [31:0] target);
    int k;
    bus.isq_full = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.mem_req !== 1'b0 && k < 40);
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL freeze_drain: mem_req=%b, expected 0", bus.mem_req);
    end
    roll_back    = 1'b1;
    roll_back_pc = target;
    tick();
    roll_back = 1'b0;
    m_pc      = target;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b, expected 0", bus.mem_req); end
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h, expected 0", bus.mem_addr); end
    n_cmp++; if (bus.instruction_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b, expected 0", bus.instruction_ready); end
    n_cmp++; if (bus.instruction_out !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h, expected 0", bus.instruction_out); end
    n_cmp++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc_out: got %h, expected 0", bus.pc_out); end
    #2 rst_in = 1'b1;
  endtask

  task automatic test_cold_start();
    wait_mem_req("cold_req", 10);
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL cold_addr: got %h, expected 0", bus.mem_addr); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL cold_hold: mem_req=%b, expected 1", bus.mem_req); end
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem_word(32'h0);
    mark(32'h0);
    tick();
    bus.mem_ready = 1'b0;
    n_cmp++; if (bus.instruction_ready !== 1'b1) begin n_err++; $display("FAIL cold_push: ready=%b, expected 1", bus.instruction_ready); end
    n_cmp++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL cold_pc: got %h, expected 0", bus.pc_out); end
    n_cmp++; if (bus.instruction_out !== 32'h0000_0013) begin n_err++; $display("FAIL cold_word: got %h, expected 00000013", bus.instruction_out); end
    cnt      = -1;
    mem_auto = 1'b1;
    wait_mem_req("next_req", 6);
    n_cmp++; if (bus.mem_addr !== 32'h4) begin n_err++; $display("FAIL next_addr: got %h, expected 4", bus.mem_addr); end
  endtask

  task automatic test_loop();
    int k;
    k = 0;
    while (m_pc < 32'h34 && k < 300) begin
      tick();
      k++;
    end
    n_cmp++;
    if (m_pc < 32'h34) begin n_err++; $display("FAIL warm_up: stream pc %h, expected >= 00000034", m_pc); end
    freeze_and_rollback(32'h0);
    bus.isq_full = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++;
      if (bus.instruction_ready !== 1'((i % 2) == 1)) begin
        n_err++;
        $display("FAIL loop_cadence: cycle %0d ready=%b, expected %0d", i, bus.instruction_ready, (i % 2));
      end
      if ((i % 2) == 1) begin
        n_cmp++;
        if (bus.pc_out !== 32'(4 * ((i - 1) / 2))) begin
          n_err++;
          $display("FAIL loop_pc: got %h, expected %h", bus.pc_out, 32'(4 * ((i - 1) / 2)));
        end
      end
      n_cmp++;
      if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL loop_no_req: mem_req=%b at cycle %0d, expected 0", bus.mem_req, i); end
    end
  endtask

  task automatic test_isq_full();
    logic [31:0] saved;
    int k;
    freeze_and_rollback(32'h0);
    bus.isq_full = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.isq_full = 1'b1;
    tick();
    saved = m_pc;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (bus.instruction_ready !== 1'b0) begin n_err++; $display("FAIL full_no_push: ready=%b pc_out=%h, expected no push", bus.instruction_ready, bus.pc_out); end
    end
    bus.isq_full = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.instruction_ready !== 1'b1 && k < 2);
    n_cmp++;
    if (bus.instruction_ready !== 1'b1) begin n_err++; $display("FAIL full_release: no push within 2 cycles, expected one"); end
    n_cmp++;
    if (bus.pc_out !== saved) begin n_err++; $display("FAIL full_release_pc: got %h, expected %h", bus.pc_out, saved); end
  endtask

  task automatic test_rollback_wait();
    freeze_and_rollback(32'h40);
    mem_auto      = 1'b0;
    bus.mem_ready = 1'b0;
    bus.isq_full  = 1'b0;
    wait_mem_req("rbw_req", 5);
    n_cmp++; if (bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL rbw_addr: got %h, expected 00000040", bus.mem_addr); end
    tick();
    roll_back    = 1'b1;
    roll_back_pc = 32'h100;
    tick();
    roll_back = 1'b0;
    m_pc      = 32'h100;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
        n_err++;
        $display("FAIL rbw_hold: mem_req=%b mem_addr=%h, expected 1 / 00000040", bus.mem_req, bus.mem_addr);
      end
      if (i < 2) tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem_word(32'h40);
    mark(32'h40);
    tick();
    bus.mem_ready = 1'b0;
    n_cmp++; if (bus.instruction_ready !== 1'b0) begin n_err++; $display("FAIL rbw_no_push: ready=%b pc_out=%h, expected no push", bus.instruction_ready, bus.pc_out); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rbw_done: mem_req=%b, expected 0", bus.mem_req); end
    wait_mem_req("rbw_next_req", 5);
    n_cmp++; if (bus.mem_addr !== 32'h100) begin n_err++; $display("FAIL rbw_next_addr: got %h, expected 00000100", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_data  = mem_word(32'h100);
    mark(32'h100);
    tick();
    bus.mem_ready = 1'b0;
    cnt      = -1;
    mem_auto = 1'b1;
    freeze_and_rollback(32'h40);
    bus.isq_full = 1'b0;
    tick();
    n_cmp++; if (bus.instruction_ready !== 1'b1 || bus.pc_out !== 32'h40) begin n_err++; $display("FAIL rbw_line_valid: ready=%b pc_out=%h, expected hit push at 00000040", bus.instruction_ready, bus.pc_out); end
    tick();
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rbw_hit_no_req: mem_req=%b, expected 0", bus.mem_req); end
  endtask

  task automatic test_rdy_stall();
    freeze_and_rollback(32'h200);
    mem_auto      = 1'b0;
    bus.mem_ready = 1'b0;
    bus.isq_full  = 1'b0;
    wait_mem_req("rdy_req", 5);
    n_cmp++; if (bus.mem_addr !== 32'h200) begin n_err++; $display("FAIL rdy_addr: got %h, expected 00000200", bus.mem_addr); end
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = (i == 2);
      bus.mem_data  = mem_word(32'h200);
      tick();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.instruction_ready !== 1'b0) begin
        n_err++;
        $display("FAIL rdy_frozen: mem_req=%b mem_addr=%h ready=%b, expected 1 / 00000200 / 0", bus.mem_req, bus.mem_addr, bus.instruction_ready);
      end
    end
    bus.mem_ready = 1'b0;
    rdy_in        = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.instruction_ready !== 1'b0) begin n_err++; $display("FAIL rdy_pulse_ignored: mem_req=%b ready=%b, expected 1 / 0", bus.mem_req, bus.instruction_ready); end
    bus.mem_ready = 1'b1;
    mark(32'h200);
    tick();
    bus.mem_ready = 1'b0;
    n_cmp++; if (bus.instruction_ready !== 1'b1 || bus.pc_out !== 32'h200) begin n_err++; $display("FAIL rdy_complete: ready=%b pc_out=%h, expected 1 / 00000200", bus.instruction_ready, bus.pc_out); end
    cnt      = -1;
    mem_auto = 1'b1;
  endtask

  task automatic test_jal();
    logic [31:0] exp_next;
`ifdef FETCH_JAL_PREDICT_EN
    exp_next = 32'h30;
`else
    exp_next = 32'h24;
`endif
    freeze_and_rollback(32'h20);
    bus.isq_full = 1'b0;
    wait_push("jal_push", 20);
    n_cmp++; if (last_pc !== 32'h20) begin n_err++; $display("FAIL jal_pc: got %h, expected 00000020", last_pc); end
    wait_push("jal_follow", 20);
    n_cmp++; if (last_pc !== exp_next) begin n_err++; $display("FAIL jal_next_pc: got %h, expected %h", last_pc, exp_next); end
  endtask

  task automatic test_random();
    int start;
    start = n_push;
    for (int i = 0; i < 400; i++) begin
      bus.isq_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        roll_back    = 1'b1;
        roll_back_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        tick();
        roll_back = 1'b0;
        m_pc      = roll_back_pc;
      end else begin
        tick();
      end
    end
    bus.isq_full = 1'b0;
    n_cmp++;
    if (n_push - start < 20) begin n_err++; $display("FAIL random_progress: %0d pushes, expected at least 20", n_push - start); end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    n_push        = 0;
    cnt           = -1;
    mem_auto      = 1'b0;
    prev_ir       = 1'b0;
    m_pc          = 32'h0;
    last_pc       = 32'h0;
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    roll_back     = 1'b0;
    roll_back_pc  = 32'h0;
    bus.isq_full  = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = 32'h0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end

    test_reset();
    test_cold_start();
    test_loop();
    test_isq_full();
    test_rollback_wait();
    test_rdy_stall();
    test_jal();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
